muldiv_unit: RTL and testbench



---
 rtl/muldiv_if.sv | 23 ++
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Request/response bundle between the issue logic and the multiply/divide unit.
interface muldiv_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_addr_out;
  logic        reg_write_enable;

  modport master (
    output start, funct3, rs1_data, rs2_data, rd_addr_in,
    input  busy, done, result, rd_addr_out, reg_write_enable
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, rd_addr_in,
    output busy, done, result, rd_addr_out, reg_write_enable
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: fixed 34-cycle latency from acceptance to done.
// Multiply is shift-add on magnitudes, divide is restoring division on magnitudes; the
// sign correction and output selection happen in a single FIX cycle.
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ITERS = 32
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  localparam logic [5:0] LastIter = 6'(ITERS - 1);

  state_e              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [4:0]          rd_q, rd_d;
  logic [XLEN-1:0]     a_q, a_d;        // multiplicand / dividend magnitude
  logic [XLEN-1:0]     b_q, b_d;        // multiplier / divisor magnitude
  logic [XLEN-1:0]     rs1_q, rs1_d;    // raw rs1, returned by REM on divide-by-zero
  logic                neg_q, neg_d;    // product / quotient must be negated
  logic                a_neg_q, a_neg_d; // dividend sign, applied to the remainder
  logic [2*XLEN-1:0]   acc_q, acc_d;    // {hi, lo}: product, or {remainder, quotient}
  logic [XLEN-1:0]     result_q, result_d;

  // Operand decode for the accepting cycle
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  // Single-iteration datapaths
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;

  // FIX-cycle correction
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic              b_zero;

  // Operand signedness and magnitudes from the live request
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    unique case (bus.funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010:  a_signed = 1'b1;
      default: ;
    endcase
    a_neg = a_signed & bus.rs1_data[XLEN-1];
    b_neg = b_signed & bus.rs2_data[XLEN-1];
    // -2^31 negates to 0x80000000, which is the correct unsigned magnitude
    a_mag = a_neg ? (~bus.rs1_data + 1'b1) : bus.rs1_data;
    b_mag = b_neg ? (~bus.rs2_data + 1'b1) : bus.rs2_data;
  end

  // One shift-add step and one restoring-divide step on the accumulator
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (div_diff[XLEN]) begin
      div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  // Sign correction and output word selection for the FIX cycle
  always_comb begin
    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix  = a_neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    b_zero   = (b_q == '0);
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    a_d      = a_q;
    b_d      = b_q;
    rs1_d    = rs1_q;
    neg_d    = neg_q;
    a_neg_d  = a_neg_q;
    acc_d    = acc_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StCalc;
          cnt_d   = '0;
          op_d    = bus.funct3;
          rd_d    = bus.rd_addr_in;
          a_d     = a_mag;
          b_d     = b_mag;
          rs1_d   = bus.rs1_data;
          neg_d   = a_neg ^ b_neg;
          a_neg_d = a_neg;
          // Low half seeds the multiplier for MUL*, the dividend for DIV/REM
          acc_d   = {{XLEN{1'b0}}, (bus.funct3[2] ? a_mag : b_mag)};
        end
      end
      StCalc: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LastIter) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d = StDone;
        unique case (op_q)
          3'b000:                 result_d = prod_fix[XLEN-1:0];
          3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
          3'b100, 3'b101:         result_d = b_zero ? '1 : quo_fix;
          default:                result_d = b_zero ? rs1_q : rem_fix;
        endcase
      end
      StDone: begin
        // A start seen here is deliberately dropped; acceptance waits for IDLE
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rs1_q    <= '0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rs1_q    <= rs1_d;
      neg_q    <= neg_d;
      a_neg_q  <= a_neg_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // Status and writeback outputs
  always_comb begin
    bus.busy             = (state_q != StIdle);
    bus.done             = (state_q == StDone);
    bus.reg_write_enable = (state_q == StDone);
    bus.result           = result_q;
    bus.rd_addr_out      = rd_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: reset, abort, multiply/divide results, special cases,
// held start and back-to-back operations, with latency checked against 34 cycles.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  muldiv_if bus ();

  muldiv_unit #(.XLEN(32), .ITERS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Issue one op from IDLE and wait for done; lat is the cycle index of done (1 = first
  // cycle after the accepting edge), 100 means done never came.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output int lat);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.funct3     = f;
    bus.rs1_data   = a;
    bus.rs2_data   = b;
    bus.rd_addr_in = rd;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %h want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %h want 0", bus.done); end
    n_cmp++; if (bus.reg_write_enable !== 1'b0) begin n_bad++; $display("FAIL reset_wen got %h want 0", bus.reg_write_enable); end
    n_cmp++; if (bus.result !== 32'h0) begin n_bad++; $display("FAIL reset_result got %h want 0", bus.result); end
    n_cmp++; if (bus.rd_addr_out !== 5'd0) begin n_bad++; $display("FAIL reset_rd got %h want 0", bus.rd_addr_out); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_abort();
    logic [31:0] res;
    int lat;
    int seen;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.rs1_data = 32'd7; bus.rs2_data = 32'd6;
    bus.rd_addr_in = 5'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %h want 0", bus.busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.reg_write_enable !== 1'b0) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
    run_op(3'b000, 32'd7, 32'd6, 5'd3, res, lat);
    n_cmp++; if (res !== 32'd42) begin n_bad++; $display("FAIL abort_rerun_result got %h want %h", res, 32'd42); end
    n_cmp++; if (lat != 34) begin n_bad++; $display("FAIL abort_rerun_latency got %0d want 34", lat); end
  endtask

  task automatic test_mul();
    logic [31:0] res;
    int lat;
    logic [2:0]  ops  [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
    logic [31:0] want [4] = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, res, lat);
      n_cmp++; if (res !== want[i]) begin n_bad++; $display("FAIL mul_f%0d got %h want %h", ops[i], res, want[i]); end
      n_cmp++; if (lat != 34) begin n_bad++; $display("FAIL mul_f%0d_latency got %0d want 34", ops[i], lat); end
    end
    run_op(3'b000, 32'd7, 32'hFFFF_FFFA, 5'd1, res, lat);
    n_cmp++; if (res !== 32'hFFFF_FFD6) begin n_bad++; $display("FAIL mul_7xm6 got %h want %h", res, 32'hFFFF_FFD6); end
  endtask

  task automatic test_div();
    logic [31:0] res;
    int lat;
    logic [2:0]  ops  [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] as   [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs   [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] want [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], 5'd2, res, lat);
      n_cmp++; if (res !== want[i]) begin n_bad++; $display("FAIL div_case%0d got %h want %h", i, res, want[i]); end
    end
  endtask

  task automatic test_special();
    logic [31:0] res;
    int lat;
    logic [2:0]  ops  [5] = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b101};
    logic [31:0] as   [5] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd77};
    logic [31:0] bs   [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] want [5] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], 5'd4, res, lat);
      n_cmp++; if (res !== want[i]) begin n_bad++; $display("FAIL special_case%0d got %h want %h", i, res, want[i]); end
      n_cmp++; if (lat != 34) begin n_bad++; $display("FAIL special_case%0d_latency got %0d want 34", i, lat); end
    end
  endtask

  task automatic test_held_start();
    int pulses;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = 3'b101; bus.rs1_data = 32'd100; bus.rs2_data = 32'd7;
    bus.rd_addr_in = 5'd9;
    pulses = 0;
    for (int k = 1; k <= 110; k++) begin
      @(posedge clk); #1;
      // Disturb operands mid-CALC; restored well before the next acceptance edge
      if ((k % 35) >= 5 && (k % 35) <= 25) begin
        bus.rs1_data = 32'd999; bus.rs2_data = 32'd1;
      end else begin
        bus.rs1_data = 32'd100; bus.rs2_data = 32'd7;
      end
      n_cmp++;
      if (bus.reg_write_enable !== bus.done) begin
        n_bad++; $display("FAIL held_wen_eq_done k=%0d got %h want %h", k, bus.reg_write_enable, bus.done);
      end
      if (bus.done === 1'b1) begin
        pulses++;
        n_cmp++; if ((k % 35) != 34) begin n_bad++; $display("FAIL held_done_cycle got k=%0d want k%%35==34", k); end
        n_cmp++; if (bus.rd_addr_out !== 5'd9) begin n_bad++; $display("FAIL held_rd got %0d want 9", bus.rd_addr_out); end
        n_cmp++; if (bus.result !== 32'd14) begin n_bad++; $display("FAIL held_result got %h want %h", bus.result, 32'd14); end
      end
    end
    n_cmp++; if (pulses != 3) begin n_bad++; $display("FAIL held_pulse_count got %0d want 3", pulses); end
    bus.start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL held_drain_busy got %h want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int lat;
    bit hold_ok;
    run_op(3'b101, 32'd9, 32'd3, 5'd6, res, lat);
    n_cmp++; if (res !== 32'd3) begin n_bad++; $display("FAIL b2b_first got %h want 3", res); end
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.rs1_data = 32'd3; bus.rs2_data = 32'd3;
    bus.rd_addr_in = 5'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    hold_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.result !== 32'd3) hold_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++; if (hold_ok !== 1'b1) begin n_bad++; $display("FAIL b2b_hold got %0d want 1", hold_ok); end
    n_cmp++; if (bus.result !== 32'd9) begin n_bad++; $display("FAIL b2b_second got %h want 9", bus.result); end
    n_cmp++; if (lat != 34) begin n_bad++; $display("FAIL b2b_latency got %0d want 34", lat); end
    n_cmp++; if (bus.rd_addr_out !== 5'd7) begin n_bad++; $display("FAIL b2b_rd got %0d want 7", bus.rd_addr_out); end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.funct3     = 3'b000;
    bus.rs1_data   = 32'd0;
    bus.rs2_data   = 32'd0;
    bus.rd_addr_in = 5'd0;
    test_reset();
    test_abort();
    test_mul();
    test_div();
    test_special();
    test_held_start();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
